// File: rtl/rc4_pkg.sv
// Shared types and sizes for the RC4 brute-force key search.
package rc4_pkg;

  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;
  localparam int MSG_LEN  = 32;

  typedef enum logic [3:0] {
    IDLE,
    INIT_RUN,
    KSA_RUN,
    DEC_RUN,
    DEC_ACK,
    WAIT_REL,
    NEXT_KEY,
    FOUND,
    EXHAUSTED
  } state_t;

  // Any state between accepting start and reaching a final result.
  function automatic logic state_is_busy(state_t s);
    return (s == INIT_RUN) || (s == KSA_RUN) || (s == DEC_RUN) ||
           (s == DEC_ACK)  || (s == WAIT_REL) || (s == NEXT_KEY);
  endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_s_mem_arbiter.sv
// Combinational S-memory port mux: the engine owning the current scheduler state
// drives the port; in every other state writes are blocked.
module s_mem_arbiter
  import rc4_pkg::*;
(
  input  state_t              state_i,
  input  logic [S_ADDR_W-1:0] init_addr_i,
  input  logic [S_DATA_W-1:0] init_wdata_i,
  input  logic                init_wren_i,
  input  logic [S_ADDR_W-1:0] ksa_addr_i,
  input  logic [S_DATA_W-1:0] ksa_wdata_i,
  input  logic                ksa_wren_i,
  input  logic [S_ADDR_W-1:0] dec_addr_i,
  input  logic [S_DATA_W-1:0] dec_wdata_i,
  input  logic                dec_wren_i,
  output logic [S_ADDR_W-1:0] mem_addr_o,
  output logic [S_DATA_W-1:0] mem_wdata_o,
  output logic                mem_wren_o
);

  // Idle states still present the decryption address so a read stays stable,
  // but a stalled engine can never write.
  always_comb begin
    mem_addr_o  = dec_addr_i;
    mem_wdata_o = dec_wdata_i;
    mem_wren_o  = 1'b0;
    case (state_i)
      INIT_RUN: begin
        mem_addr_o  = init_addr_i;
        mem_wdata_o = init_wdata_i;
        mem_wren_o  = init_wren_i;
      end
      KSA_RUN: begin
        mem_addr_o  = ksa_addr_i;
        mem_wdata_o = ksa_wdata_i;
        mem_wren_o  = ksa_wren_i;
      end
      DEC_RUN, DEC_ACK, WAIT_REL: begin
        mem_wren_o  = dec_wren_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search scheduler: sequences init/KSA/decrypt per candidate key.
// Optional progress counter output keys_tried enabled by KEY_SEARCH_PROGRESS_EN.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int unsigned          KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_LO    = 24'h000000,
  parameter logic [KEY_WIDTH-1:0] KEY_HI    = 24'h3FFFFF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic                 busy,
  output logic                 key_found,
  output logic                 key_exhausted,
  output logic                 init_start,
  input  logic                 init_done,
  output logic                 ksa_start,
  input  logic                 ksa_done,
  output logic                 dec_start,
  input  logic                 dec_done,
  input  logic                 dec_found,
  output logic                 dec_done_ack,
  input  logic [S_ADDR_W-1:0]  init_s_addr,
  input  logic [S_DATA_W-1:0]  init_s_wdata,
  input  logic                 init_s_wren,
  input  logic [S_ADDR_W-1:0]  ksa_s_addr,
  input  logic [S_DATA_W-1:0]  ksa_s_wdata,
  input  logic                 ksa_s_wren,
  input  logic [S_ADDR_W-1:0]  dec_s_addr,
  input  logic [S_DATA_W-1:0]  dec_s_wdata,
  input  logic                 dec_s_wren,
`ifdef KEY_SEARCH_PROGRESS_EN
  output logic [KEY_WIDTH:0]   keys_tried,
`endif
  output logic [S_ADDR_W-1:0]  s_mem_addr,
  output logic [S_DATA_W-1:0]  s_mem_data_write,
  output logic                 s_mem_wren
);

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 init_start_q, init_start_d;
  logic                 ksa_start_q, ksa_start_d;
  logic                 dec_start_q, dec_start_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      key_q        <= KEY_LO;
      init_start_q <= 1'b0;
      ksa_start_q  <= 1'b0;
      dec_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      init_start_q <= init_start_d;
      ksa_start_q  <= ksa_start_d;
      dec_start_q  <= dec_start_d;
    end
  end

  // Each start pulse is raised together with the transition into its run state,
  // so it appears registered on the first cycle of that state.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    init_start_d = 1'b0;
    ksa_start_d  = 1'b0;
    dec_start_d  = 1'b0;
    case (state_q)
      IDLE, FOUND, EXHAUSTED: begin
        if (start) begin
          state_d      = INIT_RUN;
          key_d        = KEY_LO;
          init_start_d = 1'b1;
        end
      end
      INIT_RUN: begin
        if (init_done) begin
          state_d     = KSA_RUN;
          ksa_start_d = 1'b1;
        end
      end
      KSA_RUN: begin
        if (ksa_done) begin
          state_d     = DEC_RUN;
          dec_start_d = 1'b1;
        end
      end
      DEC_RUN: begin
        if (dec_done) begin
          state_d = dec_found ? FOUND : DEC_ACK;
        end
      end
      DEC_ACK: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!dec_done) begin
          state_d = NEXT_KEY;
        end
      end
      NEXT_KEY: begin
        if (key_q == KEY_HI) begin
          state_d = EXHAUSTED;
        end else begin
          key_d        = key_q + KEY_WIDTH'(1);
          state_d      = INIT_RUN;
          init_start_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef KEY_SEARCH_PROGRESS_EN
  logic [KEY_WIDTH:0] keys_tried_q;

  // A key counts as tried once it is rejected or accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keys_tried_q <= '0;
    end else if (init_start_d && (state_q != NEXT_KEY)) begin
      keys_tried_q <= '0;
    end else if ((state_q == NEXT_KEY) ||
                 ((state_q == DEC_RUN) && (state_d == FOUND))) begin
      keys_tried_q <= keys_tried_q + (KEY_WIDTH + 1)'(1);
    end
  end

  assign keys_tried = keys_tried_q;
`endif

  assign secret_key    = key_q;
  assign busy          = state_is_busy(state_q);
  assign key_found     = (state_q == FOUND);
  assign key_exhausted = (state_q == EXHAUSTED);
  assign init_start    = init_start_q;
  assign ksa_start     = ksa_start_q;
  assign dec_start     = dec_start_q;
  assign dec_done_ack  = (state_q == DEC_ACK);

  s_mem_arbiter u_arb (
    .state_i      (state_q),
    .init_addr_i  (init_s_addr),
    .init_wdata_i (init_s_wdata),
    .init_wren_i  (init_s_wren),
    .ksa_addr_i   (ksa_s_addr),
    .ksa_wdata_i  (ksa_s_wdata),
    .ksa_wren_i   (ksa_s_wren),
    .dec_addr_i   (dec_s_addr),
    .dec_wdata_i  (dec_s_wdata),
    .dec_wren_i   (dec_s_wren),
    .mem_addr_o   (s_mem_addr),
    .mem_wdata_o  (s_mem_data_write),
    .mem_wren_o   (s_mem_wren)
  );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Scoreboard bench for rc4_key_search_ctrl with behavioural engine stubs (KEY_LO=0, KEY_HI=7).
module tb_rc4_key_search_ctrl;

  localparam int NKEYS = 8;

  logic        clk, reset_n, start;
  logic [23:0] secret_key;
  logic        busy, key_found, key_exhausted;
  logic        init_start, init_done, ksa_start, ksa_done;
  logic        dec_start, dec_done, dec_found, dec_done_ack;
  logic [7:0]  init_s_addr, init_s_wdata, ksa_s_addr, ksa_s_wdata, dec_s_addr, dec_s_wdata;
  logic        init_s_wren, ksa_s_wren, dec_s_wren;
  logic [7:0]  s_mem_addr, s_mem_data_write;
  logic        s_mem_wren;

  rc4_key_search_ctrl #(
    .KEY_WIDTH (24),
    .KEY_LO    (24'h000000),
    .KEY_HI    (24'h000007)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .secret_key       (secret_key),
    .busy             (busy),
    .key_found        (key_found),
    .key_exhausted    (key_exhausted),
    .init_start       (init_start),
    .init_done        (init_done),
    .ksa_start        (ksa_start),
    .ksa_done         (ksa_done),
    .dec_start        (dec_start),
    .dec_done         (dec_done),
    .dec_found        (dec_found),
    .dec_done_ack     (dec_done_ack),
    .init_s_addr      (init_s_addr),
    .init_s_wdata     (init_s_wdata),
    .init_s_wren      (init_s_wren),
    .ksa_s_addr       (ksa_s_addr),
    .ksa_s_wdata      (ksa_s_wdata),
    .ksa_s_wren       (ksa_s_wren),
    .dec_s_addr       (dec_s_addr),
    .dec_s_wdata      (dec_s_wdata),
    .dec_s_wren       (dec_s_wren),
    .s_mem_addr       (s_mem_addr),
    .s_mem_data_write (s_mem_data_write),
    .s_mem_wren       (s_mem_wren)
  );

  typedef enum {OWN_NONE, OWN_INIT, OWN_KSA, OWN_DEC} owner_e;
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       wren;
    bit         chkData;
  } memExp_t;
  typedef struct {
    bit          found;
    logic [23:0] key;
    int          acks;
  } resExp_t;

  memExp_t     memQ[$];
  logic [23:0] keyQ[$];
  resExp_t     resQ[$];

  int checks   = 0;
  int failures = 0;

  // Engine stub state, owned by the stimulus process.
  bit initActive, ksaActive;
  int initCnt, ksaCnt, decPhase, decCnt, holdCnt;
  int foundKey, holdCfg, initLatCfg, ksaLatCfg, decLatCfg;

  // Monitor state.
  bit monPrevInit, monPrevTerm;
  int monAckCnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pickLat(input int cfg);
    return (cfg == 0) ? int'($urandom_range(1, 6)) : cfg;
  endfunction

  // One clock cycle: engine stubs react to the DUT, then push the expected S-memory view.
  task automatic stepCycle();
    owner_e     own;
    memExp_t    e;
    logic [7:0] r;
    @(posedge clk);
    #1;
    own       = OWN_NONE;
    init_done = 1'b0;
    ksa_done  = 1'b0;
    r = 8'($urandom);
    init_s_addr  = r;
    ksa_s_addr   = r + 8'd85;
    dec_s_addr   = r + 8'd170;
    init_s_wdata = 8'($urandom);
    ksa_s_wdata  = 8'($urandom);
    dec_s_wdata  = 8'($urandom);
    init_s_wren  = 1'($urandom);
    ksa_s_wren   = 1'($urandom);
    dec_s_wren   = 1'($urandom);
    if (!reset_n) begin
      initActive = 0;
      ksaActive  = 0;
      decPhase   = 0;
      dec_done   = 1'b0;
      dec_found  = 1'b0;
      return;
    end
    if (init_start) begin
      initActive = 1;
      initCnt    = pickLat(initLatCfg);
      if (decPhase == 4) begin
        decPhase = 0;
        dec_done = 1'b0;
      end
    end
    if (initActive) begin
      own = OWN_INIT;
      if (initCnt == 0) begin
        init_done  = 1'b1;
        initActive = 0;
      end else initCnt--;
    end
    if (ksa_start) begin
      ksaActive = 1;
      ksaCnt    = pickLat(ksaLatCfg);
    end
    if (ksaActive) begin
      own = OWN_KSA;
      if (ksaCnt == 0) begin
        ksa_done  = 1'b1;
        ksaActive = 0;
      end else ksaCnt--;
    end
    if (dec_start) begin
      decPhase = 1;
      decCnt   = pickLat(decLatCfg);
    end
    case (decPhase)
      0: dec_found = 1'($urandom);
      1: begin
        own = OWN_DEC;
        if (decCnt == 0) begin
          dec_done  = 1'b1;
          dec_found = (int'(secret_key) == foundKey);
          decPhase  = dec_found ? 4 : 2;
        end else begin
          decCnt--;
          dec_found = 1'($urandom);
        end
      end
      2: begin
        own = OWN_DEC;
        if (dec_done_ack) begin
          holdCnt  = holdCfg;
          decPhase = 3;
        end
      end
      3: begin
        own = OWN_DEC;
        if (holdCnt == 0) begin
          dec_done = 1'b0;
          decPhase = 0;
        end else holdCnt--;
      end
      default: ;
    endcase
    case (own)
      OWN_INIT: e = '{init_s_addr, init_s_wdata, init_s_wren, 1'b1};
      OWN_KSA:  e = '{ksa_s_addr, ksa_s_wdata, ksa_s_wren, 1'b1};
      OWN_DEC:  e = '{dec_s_addr, dec_s_wdata, dec_s_wren, 1'b1};
      default:  e = '{dec_s_addr, 8'h00, 1'b0, 1'b0};
    endcase
    memQ.push_back(e);
  endtask

  // One full search: the expected key sequence and outcome follow from which key decrypts.
  task automatic applyStimulus(input int fk, input int hold, input int li, input int lk, input int ld);
    resExp_t r;
    int      last;
    bit      done;
    foundKey   = fk;
    holdCfg    = hold;
    initLatCfg = li;
    ksaLatCfg  = lk;
    decLatCfg  = ld;
    last = (fk < NKEYS) ? fk : NKEYS - 1;
    for (int k = 0; k <= last; k++) keyQ.push_back(24'(k));
    r.found = (fk < NKEYS);
    r.key   = 24'(last);
    r.acks  = (fk < NKEYS) ? fk : NKEYS;
    resQ.push_back(r);
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      stepCycle();
      done = key_found || key_exhausted;
    end
    if (!done) check("search_timeout", 32'(done), 32'd1);
    repeat (3) stepCycle();
  endtask

  task automatic checkOutput();
    memExp_t e;
    resExp_t r;
    bit      term;
    if (!reset_n) begin
      check("reset_flags",
            32'({busy, key_found, key_exhausted, init_start, ksa_start, dec_start, dec_done_ack, s_mem_wren}),
            32'd0);
      check("reset_key", 32'(secret_key), 32'd0);
      monAckCnt   = 0;
      monPrevInit = 0;
      monPrevTerm = 0;
      return;
    end
    if (memQ.size() > 0) begin
      e = memQ.pop_front();
      check("s_mem_addr", 32'(s_mem_addr), 32'(e.addr));
      check("s_mem_wren", 32'(s_mem_wren), 32'(e.wren));
      if (e.chkData) check("s_mem_data_write", 32'(s_mem_data_write), 32'(e.data));
    end
    if (init_start) begin
      check("init_start_back_to_back", 32'(monPrevInit), 32'd0);
      if (keyQ.size() == 0) check("init_start_expected", 32'(init_start), 32'd0);
      else check("key_at_init_start", 32'(secret_key), 32'(keyQ.pop_front()));
    end
    monPrevInit = init_start;
    if (dec_done_ack) monAckCnt++;
    term = key_found || key_exhausted;
    if (term && !monPrevTerm) begin
      if (resQ.size() == 0) check("termination_expected", 32'(term), 32'd0);
      else begin
        r = resQ.pop_front();
        check("key_found", 32'(key_found), 32'(r.found));
        check("key_exhausted", 32'(key_exhausted), 32'(!r.found));
        check("final_key", 32'(secret_key), 32'(r.key));
        check("ack_count", 32'(monAckCnt), 32'(r.acks));
        check("busy_at_end", 32'(busy), 32'd0);
        check("keys_left", 32'(keyQ.size()), 32'd0);
        monAckCnt = 0;
      end
    end
    monPrevTerm = term;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  initial begin
    bit reached, pulsed;
    reset_n = 1'b0;
    start   = 1'b0;
    init_done = 1'b0; ksa_done = 1'b0; dec_done = 1'b0; dec_found = 1'b0;
    init_s_addr = '0; init_s_wdata = '0; init_s_wren = 1'b0;
    ksa_s_addr = '0; ksa_s_wdata = '0; ksa_s_wren = 1'b0;
    dec_s_addr = '0; dec_s_wdata = '0; dec_s_wren = 1'b0;
    foundKey = 99; holdCfg = 0; initLatCfg = 0; ksaLatCfg = 0; decLatCfg = 0;
    repeat (3) stepCycle();
    reset_n = 1'b1;
    repeat (3) stepCycle();

    $display("[TB] first key decrypts, engines 10/20/10 cycles");
    applyStimulus(0, 0, 10, 20, 10);
    $display("[TB] key 2 decrypts");
    applyStimulus(2, 0, 0, 0, 0);
    $display("[TB] no key decrypts");
    applyStimulus(99, 0, 0, 0, 0);
    $display("[TB] dec_done held 3 cycles after ack");
    applyStimulus(3, 3, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 0, 0, 0);
    end

    $display("[TB] reset during KSA on key 5, start pulse while busy");
    foundKey = 99; holdCfg = 0; initLatCfg = 0; ksaLatCfg = 0; decLatCfg = 0;
    for (int k = 0; k < NKEYS; k++) keyQ.push_back(24'(k));
    resQ.push_back('{1'b0, 24'd7, NKEYS});
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    reached = 0;
    pulsed  = 0;
    for (int c = 0; c < 3000 && !reached; c++) begin
      stepCycle();
      start = 1'b0;
      if (!pulsed && secret_key == 24'd3 && decPhase == 1) begin
        start  = 1'b1;
        pulsed = 1;
      end
      reached = ksaActive && (secret_key == 24'd5);
    end
    if (!reached) check("reach_key5_ksa", 32'(reached), 32'd1);
    reset_n = 1'b0;
    keyQ.delete();
    resQ.delete();
    memQ.delete();
    repeat (2) stepCycle();
    reset_n = 1'b1;
    repeat (3) stepCycle();
    applyStimulus(1, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
